control_sequencer: RTL and testbench

Hardwired control unit that sits directly upstream of the CPU datapath. It generates the per-step control signals PCout, MARin, IncPC, Read, MDRin, IRin, Yin, Zlowout, R-select and ALU op. It sequences fetch (T0–T2) and execute (T3–T6) for the register-register ALU instruction subset, plus NOP and HALT. It reads the datapath's IR and a memory-ready handshake.

---
 rtl/ctrl_pkg.sv | 71 +++++++
 rtl/control_sequencer_if.sv | 31 +++
 rtl/ctrl_decode.sv | 24 ++
 rtl/control_sequencer.sv | 166 ++++++++++++++++
 tb/tb_control_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types, opcode/ALU encodings and opcode classification for the
// hardwired control sequencer.
package ctrl_pkg;

  localparam int OPC_W = 5;
  localparam int ALU_W = 5;

  typedef logic [OPC_W-1:0] opc_t;
  typedef logic [ALU_W-1:0] alu_t;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALTED
  } state_t;

  localparam opc_t OP_ADD  = 5'b00011;
  localparam opc_t OP_SUB  = 5'b00100;
  localparam opc_t OP_SHR  = 5'b00101;
  localparam opc_t OP_SHL  = 5'b00110;
  localparam opc_t OP_ROR  = 5'b00111;
  localparam opc_t OP_ROL  = 5'b01000;
  localparam opc_t OP_NOT  = 5'b01001;
  localparam opc_t OP_NEG  = 5'b01010;
  localparam opc_t OP_AND  = 5'b01011;
  localparam opc_t OP_OR   = 5'b01100;
  localparam opc_t OP_MUL  = 5'b01101;
  localparam opc_t OP_DIV  = 5'b01110;
  localparam opc_t OP_NOP  = 5'b11010;
  localparam opc_t OP_HALT = 5'b11011;

  // ALU codes mirror the opcode except NOT, whose ALU encoding is relocated.
  localparam alu_t ALU_NONE = 5'b00000;
  localparam alu_t ALU_NOT  = 5'b10001;

  function automatic logic is_binary(input opc_t opc);
    logic r;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_unary(input opc_t opc);
    return (opc == OP_NOT) || (opc == OP_NEG);
  endfunction

  function automatic logic is_muldiv(input opc_t opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

  function automatic alu_t alu_lookup(input opc_t opc);
    alu_t r;
    if (opc == OP_NOT)
      r = ALU_NOT;
    else if (is_binary(opc) || is_unary(opc))
      r = alu_t'(opc);
    else
      r = ALU_NONE;
    return r;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath-facing bundle of the control sequencer: IR/handshake inputs and
// all per-step bus drivers, register enables and register-field selects.
interface control_sequencer_if;

  logic [31:0]               IR;
  logic                      mem_ready;
  logic                      Stop;

  logic                      PCout, Zlowout, ZHighout, MDRout;
  logic                      MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
  logic                      IncPC, Read;
  logic                      Gra, Grb, Grc, Rin, Rout;
  logic [ctrl_pkg::ALU_W-1:0] ALUop;
  logic                      Run;
  logic                      illegal_op;

  modport master (
    input  IR, mem_ready, Stop,
    output PCout, Zlowout, ZHighout, MDRout,
    output MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
    output IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALUop, Run, illegal_op
  );

  modport slave (
    output IR, mem_ready, Stop,
    input  PCout, Zlowout, ZHighout, MDRout,
    input  MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
    input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALUop, Run, illegal_op
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier and ALU-code lookup for the sequencer.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  opc_t opcode,
  output logic binary,
  output logic unary,
  output logic muldiv,
  output logic halt,
  output logic known,
  output alu_t alu_op
);

  always_comb begin
    binary = is_binary(opcode);
    unary  = is_unary(opcode);
    muldiv = is_muldiv(opcode);
    halt   = (opcode == OP_HALT);
    known  = is_binary(opcode) | is_unary(opcode) |
             (opcode == OP_HALT) | (opcode == OP_NOP);
    alu_op = alu_lookup(opcode);
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the register-register ALU subset.
// Build option: CTRL_ILLEGAL_TRAP_EN makes unknown opcodes flag illegal_op and halt.
//
// state   | meaning
// RESET   | after Clear; all outputs 0
// T0      | PC to MAR, increment PC into Z
// T1      | memory read; PC updated on first cycle, wait for mem_ready
// T2      | MDR to IR
// T3      | first execute step (operand B or unary op), decode dispatch
// T4      | binary op with operand C into Z
// T5      | Z low to Ra (or LO for MUL/DIV)
// T6      | Z high to HI (MUL/DIV only)
// HALTED  | stopped until Clear
module control_sequencer
  import ctrl_pkg::*;
(
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_t UNKNOWN_NEXT = S_HALTED;
`else
  localparam state_t UNKNOWN_NEXT = S_T0;
`endif

  state_t state;
  logic   t1_first;

  opc_t   opcode;
  logic   op_binary, op_unary, op_muldiv, op_halt, op_known;
  alu_t   op_alu;
  logic   unused_ir;

  assign opcode    = bus.IR[31 -: OPC_W];
  assign unused_ir = ^bus.IR[31-OPC_W:0];

  ctrl_decode u_decode (
    .opcode (opcode),
    .binary (op_binary),
    .unary  (op_unary),
    .muldiv (op_muldiv),
    .halt   (op_halt),
    .known  (op_known),
    .alu_op (op_alu)
  );

  // t1_first marks the entry cycle of T1 so the PC is written exactly once
  // however long memory stalls.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= S_RESET;
      t1_first <= 1'b0;
    end else begin
      t1_first <= 1'b0;
      case (state)
        S_RESET: state <= S_T0;
        S_T0: begin
          if (bus.Stop) begin
            state <= S_HALTED;
          end else begin
            state    <= S_T1;
            t1_first <= 1'b1;
          end
        end
        S_T1: if (bus.mem_ready) state <= S_T2;
        S_T2: state <= S_T3;
        S_T3: begin
          if (op_binary)      state <= S_T4;
          else if (op_unary)  state <= S_T5;
          else if (op_halt)   state <= S_HALTED;
          else if (!op_known) state <= UNKNOWN_NEXT;
          else                state <= S_T0;
        end
        S_T4:     state <= S_T5;
        S_T5:     state <= op_muldiv ? S_T6 : S_T0;
        S_T6:     state <= S_T0;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    bus.PCout      = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.ZHighout   = 1'b0;
    bus.MDRout     = 1'b0;
    bus.MARin      = 1'b0;
    bus.PCin       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.ZLowIn     = 1'b0;
    bus.ZHighIn    = 1'b0;
    bus.HIin       = 1'b0;
    bus.LOin       = 1'b0;
    bus.IncPC      = 1'b0;
    bus.Read       = 1'b0;
    bus.Gra        = 1'b0;
    bus.Grb        = 1'b0;
    bus.Grc        = 1'b0;
    bus.Rin        = 1'b0;
    bus.Rout       = 1'b0;
    bus.ALUop      = ALU_NONE;
    bus.Run        = (state != S_RESET) && (state != S_HALTED);
    bus.illegal_op = 1'b0;

    case (state)
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.ZLowIn = 1'b1;
      end
      S_T1: begin
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        bus.Zlowout = t1_first;
        bus.PCin    = t1_first;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (op_binary) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end else if (op_unary) begin
          bus.Grb    = 1'b1;
          bus.Rout   = 1'b1;
          bus.ZLowIn = 1'b1;
          bus.ALUop  = op_alu;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        bus.illegal_op = !op_known;
`endif
      end
      S_T4: begin
        bus.Grc     = 1'b1;
        bus.Rout    = 1'b1;
        bus.ZLowIn  = 1'b1;
        bus.ZHighIn = op_muldiv;
        bus.ALUop   = op_alu;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (op_muldiv) begin
          bus.LOin = 1'b1;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        bus.ZHighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle expected output
// vectors queued from an instruction table, drained and compared each cycle.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Clear;

  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus.master)
  );

  always #5 Clock = ~Clock;

  localparam logic [26:0] M_PCOUT    = 27'h1 << 26;
  localparam logic [26:0] M_ZLOWOUT  = 27'h1 << 25;
  localparam logic [26:0] M_ZHIGHOUT = 27'h1 << 24;
  localparam logic [26:0] M_MDROUT   = 27'h1 << 23;
  localparam logic [26:0] M_MARIN    = 27'h1 << 22;
  localparam logic [26:0] M_PCIN     = 27'h1 << 21;
  localparam logic [26:0] M_MDRIN    = 27'h1 << 20;
  localparam logic [26:0] M_IRIN     = 27'h1 << 19;
  localparam logic [26:0] M_YIN      = 27'h1 << 18;
  localparam logic [26:0] M_ZLOWIN   = 27'h1 << 17;
  localparam logic [26:0] M_ZHIGHIN  = 27'h1 << 16;
  localparam logic [26:0] M_HIIN     = 27'h1 << 15;
  localparam logic [26:0] M_LOIN     = 27'h1 << 14;
  localparam logic [26:0] M_INCPC    = 27'h1 << 13;
  localparam logic [26:0] M_READ     = 27'h1 << 12;
  localparam logic [26:0] M_GRA      = 27'h1 << 11;
  localparam logic [26:0] M_GRB      = 27'h1 << 10;
  localparam logic [26:0] M_GRC      = 27'h1 << 9;
  localparam logic [26:0] M_RIN      = 27'h1 << 8;
  localparam logic [26:0] M_ROUT     = 27'h1 << 7;
  localparam logic [26:0] M_RUN      = 27'h1 << 1;
  localparam logic [26:0] M_ILLEGAL  = 27'h1;
  localparam logic [26:0] M_NONE     = 27'h0;

  localparam int C_BIN  = 0;
  localparam int C_UN   = 1;
  localparam int C_MD   = 2;
  localparam int C_NOP  = 3;
  localparam int C_HALT = 4;
  localparam int C_TRAP = 5;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam int C_UNK = C_TRAP;
`else
  localparam int C_UNK = C_NOP;
`endif

  localparam int WATCHDOG_CYCLES = 5000;

  wire [26:0] obs = {bus.PCout, bus.Zlowout, bus.ZHighout, bus.MDRout,
                     bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
                     bus.ZLowIn, bus.ZHighIn, bus.HIin, bus.LOin,
                     bus.IncPC, bus.Read, bus.Gra, bus.Grb, bus.Grc,
                     bus.Rin, bus.Rout, bus.ALUop, bus.Run, bus.illegal_op};

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    logic        stop;
    logic        clr;
    logic [26:0] exp;
    string       tag;
  } step_t;

  typedef struct {
    logic [4:0] opc;
    logic [4:0] alu;
    int         cls;
    int         waits;
    logic       stop_mid;
  } vec_t;

  step_t sbq[$];
  vec_t  vecs[15];
  int    tests = 0;
  int    fails = 0;
  logic  done  = 1'b0;

  task automatic check(input logic [26:0] e, input string tag);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL %s: got %b want %b", tag, obs, e);
    end
  endtask

  function automatic void push(input logic [31:0] ir, input logic mr, input logic stop,
                               input logic clr, input logic [26:0] e, input string tag);
    step_t s;
    s.ir = ir; s.mr = mr; s.stop = stop; s.clr = clr; s.exp = e; s.tag = tag;
    sbq.push_back(s);
  endfunction

  // HALTED for two cycles, then Clear for one cycle back through RESET.
  function automatic void push_halt_recover(input logic [31:0] ir, input string tag);
    push(ir, 1'b1, 1'b0, 1'b0, M_NONE, {tag, "_halted"});
    push(ir, 1'b1, 1'b0, 1'b1, M_NONE, {tag, "_halted2"});
    push(ir, 1'b1, 1'b0, 1'b0, M_NONE, {tag, "_reset"});
  endfunction

  function automatic void push_instr(input logic [4:0] opc, input logic [4:0] alu, input int cls,
                                     input int waits, input logic st, input logic clr_t4,
                                     input string tag);
    logic [31:0] ir;
    logic [26:0] a;
    logic        md;
    ir = {opc, 27'h2920000};
    a  = 27'(alu) << 2;
    md = (cls == C_MD);
    push(ir, 1'b1, 1'b0, 1'b0, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN, {tag, "_t0"});
    for (int w = 0; w <= waits; w++)
      push(ir, (w == waits), st, 1'b0,
           ((w == 0) ? (M_ZLOWOUT | M_PCIN) : M_NONE) | M_READ | M_MDRIN | M_RUN, {tag, "_t1"});
    push(ir, 1'b1, st, 1'b0, M_MDROUT | M_IRIN | M_RUN, {tag, "_t2"});
    case (cls)
      C_BIN, C_MD: begin
        push(ir, 1'b1, st, 1'b0, M_GRB | M_ROUT | M_YIN | M_RUN, {tag, "_t3"});
        push(ir, 1'b1, st, clr_t4,
             M_GRC | M_ROUT | M_ZLOWIN | (md ? M_ZHIGHIN : M_NONE) | a | M_RUN, {tag, "_t4"});
        if (clr_t4) begin
          push(ir, 1'b1, 1'b0, 1'b0, M_NONE, {tag, "_aborted"});
        end else begin
          push(ir, 1'b1, st, 1'b0,
               M_ZLOWOUT | (md ? M_LOIN : (M_GRA | M_RIN)) | M_RUN, {tag, "_t5"});
          if (md) push(ir, 1'b1, st, 1'b0, M_ZHIGHOUT | M_HIIN | M_RUN, {tag, "_t6"});
        end
      end
      C_UN: begin
        push(ir, 1'b1, st, 1'b0, M_GRB | M_ROUT | M_ZLOWIN | a | M_RUN, {tag, "_t3"});
        push(ir, 1'b1, st, 1'b0, M_ZLOWOUT | M_GRA | M_RIN | M_RUN, {tag, "_t5"});
      end
      C_NOP: push(ir, 1'b1, st, 1'b0, M_RUN, {tag, "_t3"});
      C_HALT: begin
        push(ir, 1'b1, st, 1'b0, M_RUN, {tag, "_t3"});
        push_halt_recover(ir, tag);
      end
      default: begin
        push(ir, 1'b1, st, 1'b0, M_RUN | M_ILLEGAL, {tag, "_t3trap"});
        push_halt_recover(ir, tag);
      end
    endcase
  endfunction

  initial begin
    for (int c = 0; c < WATCHDOG_CYCLES; c++) begin
      @(posedge Clock);
      if (done) break;
    end
    if (!done) begin
      fails++;
      $display("FAIL watchdog: run did not complete within %0d cycles", WATCHDOG_CYCLES);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    Clear         = 1'b1;
    bus.IR        = 32'h0;
    bus.mem_ready = 1'b0;
    bus.Stop      = 1'b0;

    vecs[0]  = '{5'b01001, 5'b10001, C_UN,  0, 1'b0};
    vecs[1]  = '{5'b00011, 5'b00011, C_BIN, 3, 1'b0};
    vecs[2]  = '{5'b00100, 5'b00100, C_BIN, 0, 1'b1};
    vecs[3]  = '{5'b00101, 5'b00101, C_BIN, 1, 1'b0};
    vecs[4]  = '{5'b00110, 5'b00110, C_BIN, 0, 1'b0};
    vecs[5]  = '{5'b00111, 5'b00111, C_BIN, 0, 1'b0};
    vecs[6]  = '{5'b01000, 5'b01000, C_BIN, 2, 1'b0};
    vecs[7]  = '{5'b01010, 5'b01010, C_UN,  0, 1'b1};
    vecs[8]  = '{5'b01011, 5'b01011, C_BIN, 0, 1'b0};
    vecs[9]  = '{5'b01100, 5'b01100, C_BIN, 0, 1'b0};
    vecs[10] = '{5'b01101, 5'b01101, C_MD,  0, 1'b0};
    vecs[11] = '{5'b01110, 5'b01110, C_MD,  2, 1'b1};
    vecs[12] = '{5'b11010, 5'b00000, C_NOP, 0, 1'b0};
    vecs[13] = '{5'b11111, 5'b00000, C_UNK, 0, 1'b0};
    vecs[14] = '{5'b00000, 5'b00000, C_UNK, 1, 1'b0};

    // Two cycles of Clear, then the first instruction fetch.
    push(32'h0, 1'b0, 1'b0, 1'b1, M_NONE, "reset0");
    push(32'h0, 1'b0, 1'b0, 1'b0, M_NONE, "reset1");

    foreach (vecs[i])
      push_instr(vecs[i].opc, vecs[i].alu, vecs[i].cls, vecs[i].waits,
                 vecs[i].stop_mid, 1'b0, $sformatf("vec%0d", i));

    // Stop sampled in T0 halts before any fetch.
    push({5'b00011, 27'h0}, 1'b1, 1'b1, 1'b0,
         M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN, "stop_t0");
    push_halt_recover({5'b00011, 27'h0}, "stop");

    push_instr(5'b11011, 5'b00000, C_HALT, 0, 1'b0, 1'b0, "halt");
    push_instr(5'b00011, 5'b00011, C_BIN, 1, 1'b0, 1'b1, "clr_t4");
    push_instr(5'b01001, 5'b10001, C_UN, 0, 1'b0, 1'b0, "after_clr");

    while (sbq.size() > 0) begin
      step_t s;
      @(negedge Clock);
      s = sbq.pop_front();
      bus.IR        = s.ir;
      bus.mem_ready = s.mr;
      bus.Stop      = s.stop;
      #1;
      check(s.exp, s.tag);
      Clear = s.clr;
    end

    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    #1;
    check(M_NONE, "final_clear_reset_state");
    Clear = 1'b0;

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
